// File: rtl/cell_framer_pkg.sv
// Shared types for the cell framer: FSM state encoding, counter width and a
// counter step helper.
package cell_framer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS  = 2'd1,
    S_DISC  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] c,
                                               input logic a,
                                               input logic b);
    return c + CNT_W'(a) + CNT_W'(b);
  endfunction

endpackage

// File: rtl/cell_framer_if.sv
// Upstream beat stream and cell-FIFO write port of the cell framer.
// master = framer side, slave = source/FIFO side.
interface cell_framer_if #(
  parameter int DATA_SIZE = 36
);
  logic                 in_vld;
  logic                 in_rdy;
  logic                 in_sop;
  logic                 in_eop;
  logic                 in_err;
  logic [DATA_SIZE-1:0] in_data;
  logic                 wr_vld;
  logic [DATA_SIZE-1:0] wr_data;
  logic                 wr_eoc;
  logic                 wr_drop;
  logic                 wr_afull;

  modport master (
    input  in_vld, in_sop, in_eop, in_err, in_data, wr_afull,
    output in_rdy, wr_vld, wr_data, wr_eoc, wr_drop
  );

  modport slave (
    output in_vld, in_sop, in_eop, in_err, in_data, wr_afull,
    input  in_rdy, wr_vld, wr_data, wr_eoc, wr_drop
  );
endinterface

// File: rtl/cell_framer_stat.sv
// Good-cell and dropped-cell counters of the cell framer, wrapping modulo 2**16.
module cell_framer_stat
  import cell_framer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             eoc,
  input  logic             drop,
  input  logic             afull_rej,
  output logic [CNT_W-1:0] cell_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cell_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      cell_cnt <= cnt_add(cell_cnt, eoc & ~drop, 1'b0);
      drop_cnt <= cnt_add(drop_cnt, eoc & drop, afull_rej);
    end
  end

endmodule

// File: rtl/cell_framer.sv
// Cell framer: turns an sop/eop beat stream into length-bounded cells for a
// cell FIFO. Counters are built only when CELL_FRAMER_STAT_EN is defined.
//
//   state | meaning
//   IDLE  | between cells, waiting for an sop beat
//   PASS  | cell admitted, beats written to the FIFO
//   DISC  | discarding beats up to the next eop (afull at sop or oversize)
//   ABORT | one stall cycle replaying the held sop beat after a missing eop
module cell_framer
  import cell_framer_pkg::*;
#(
  parameter int DATA_SIZE = 36,
  parameter int MAX_LEN   = 16,
  parameter int MIN_LEN   = 1,
  parameter int LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  cell_framer_if.master    bus,
  output logic             oversize,
  output logic             orphan,
  output logic [CNT_W-1:0] cell_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
  localparam logic             SHORT_1 = (MIN_LEN > 1);
  localparam logic             ONE_MAX = (MAX_LEN <= 1);

  state_t               state, state_d;
  logic [LEN_W-1:0]     len, len_d, len_inc;
  logic                 err_acc, err_d;
  logic [DATA_SIZE-1:0] hold_data, hold_data_d;
  logic                 hold_eop, hold_eop_d;
  logic                 hold_err, hold_err_d;

  logic                 acc;
  logic                 start;
  logic [DATA_SIZE-1:0] src_data;
  logic                 src_eop, src_err;

  logic                 wr_vld_d, wr_eoc_d, wr_drop_d;
  logic [DATA_SIZE-1:0] wr_data_d;
  logic                 oversize_d, orphan_d, afull_rej_d, in_rdy_d;

  assign acc     = bus.in_vld & bus.in_rdy;
  assign len_inc = (len >= MAX_L) ? MAX_L : len + LEN_W'(1);

  always_comb begin
    state_d     = state;
    len_d       = len;
    err_d       = err_acc;
    hold_data_d = hold_data;
    hold_eop_d  = hold_eop;
    hold_err_d  = hold_err;
    wr_vld_d    = 1'b0;
    wr_data_d   = '0;
    wr_eoc_d    = 1'b0;
    wr_drop_d   = 1'b0;
    oversize_d  = 1'b0;
    orphan_d    = 1'b0;
    afull_rej_d = 1'b0;
    start       = 1'b0;
    src_data    = bus.in_data;
    src_eop     = bus.in_eop;
    src_err     = bus.in_err;

    case (state)
      S_IDLE: begin
        if (acc) begin
          if (bus.in_sop) start    = 1'b1;
          else            orphan_d = 1'b1;
        end
      end
      S_DISC: begin
        if (acc) begin
          if (bus.in_sop)      start   = 1'b1;
          else if (bus.in_eop) state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        start    = 1'b1;
        src_data = hold_data;
        src_eop  = hold_eop;
        src_err  = hold_err;
      end
      S_PASS: begin
        if (acc) begin
          if (bus.in_sop) begin
            // Missing eop: close the open cell with a dropped filler beat and
            // replay this sop beat from the hold register next cycle.
            wr_vld_d    = 1'b1;
            wr_eoc_d    = 1'b1;
            wr_drop_d   = 1'b1;
            hold_data_d = bus.in_data;
            hold_eop_d  = bus.in_eop;
            hold_err_d  = bus.in_err;
            state_d     = S_ABORT;
          end else begin
            wr_vld_d  = 1'b1;
            wr_data_d = bus.in_data;
            len_d     = len_inc;
            err_d     = err_acc | bus.in_err;
            if (bus.in_eop) begin
              wr_eoc_d  = 1'b1;
              wr_drop_d = err_acc | bus.in_err | (len_inc < MIN_L);
              state_d   = S_IDLE;
            end else if (len_inc >= MAX_L) begin
              wr_eoc_d   = 1'b1;
              wr_drop_d  = 1'b1;
              oversize_d = 1'b1;
              state_d    = S_DISC;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Cell start; wr_afull is looked at only here so admitted cells complete.
    if (start) begin
      if (bus.wr_afull) begin
        afull_rej_d = 1'b1;
        state_d     = src_eop ? S_IDLE : S_DISC;
      end else begin
        wr_vld_d  = 1'b1;
        wr_data_d = src_data;
        len_d     = LEN_W'(1);
        err_d     = src_err;
        if (src_eop) begin
          wr_eoc_d  = 1'b1;
          wr_drop_d = src_err | SHORT_1;
          state_d   = S_IDLE;
        end else if (ONE_MAX) begin
          wr_eoc_d   = 1'b1;
          wr_drop_d  = 1'b1;
          oversize_d = 1'b1;
          state_d    = S_DISC;
        end else begin
          state_d = S_PASS;
        end
      end
    end

    in_rdy_d = (state_d != S_ABORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      len         <= '0;
      err_acc     <= 1'b0;
      hold_data   <= '0;
      hold_eop    <= 1'b0;
      hold_err    <= 1'b0;
      bus.in_rdy  <= 1'b0;
      bus.wr_vld  <= 1'b0;
      bus.wr_data <= '0;
      bus.wr_eoc  <= 1'b0;
      bus.wr_drop <= 1'b0;
      oversize    <= 1'b0;
      orphan      <= 1'b0;
    end else begin
      state       <= state_d;
      len         <= len_d;
      err_acc     <= err_d;
      hold_data   <= hold_data_d;
      hold_eop    <= hold_eop_d;
      hold_err    <= hold_err_d;
      bus.in_rdy  <= in_rdy_d;
      bus.wr_vld  <= wr_vld_d;
      bus.wr_data <= wr_data_d;
      bus.wr_eoc  <= wr_eoc_d;
      bus.wr_drop <= wr_drop_d;
      oversize    <= oversize_d;
      orphan      <= orphan_d;
    end
  end

`ifdef CELL_FRAMER_STAT_EN
  cell_framer_stat u_stat (
    .clk       (clk),
    .rst_n     (rst_n),
    .eoc       (wr_vld_d & wr_eoc_d),
    .drop      (wr_drop_d),
    .afull_rej (afull_rej_d),
    .cell_cnt  (cell_cnt),
    .drop_cnt  (drop_cnt)
  );
`else
  logic stat_unused;
  assign stat_unused = afull_rej_d;
  assign cell_cnt    = '0;
  assign drop_cnt    = '0;
`endif

endmodule

// File: doc/cell_framer.md
CELL_FRAMER -- requirements
Module: cell_framer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 36: width of in_data and wr_data.
REQ-002 SHALL have parameter MAX_LEN, default 16: maximum beats per cell; equals the downstream cell FIFO's MAX_LEN.
REQ-003 SHALL have parameter MIN_LEN, default 1: minimum beats per cell.
REQ-004 SHALL have parameter LEN_W, default 8: length counter width; must satisfy 2**LEN_W > MAX_LEN.
REQ-005 SHALL have port clk, input, 1 bit: the only clock.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have upstream ports in_vld (input, 1), in_rdy (output, 1), in_sop (input, 1), in_eop (input, 1), in_err (input, 1) and in_data (input, DATA_SIZE).
REQ-008 SHALL have FIFO-side ports wr_vld (output, 1), wr_data (output, DATA_SIZE), wr_eoc (output, 1), wr_drop (output, 1) and wr_afull (input, 1).
REQ-009 SHALL have status ports oversize (output, 1, pulse), orphan (output, 1, pulse), cell_cnt (output, 16) and drop_cnt (output, 16).

Function
REQ-010 SHALL treat a beat as accepted when in_vld=1 and in_rdy=1.
REQ-011 SHALL register all wr_* outputs; wr_vld asserts exactly 1 cycle after the accepted beat that produces it.
REQ-012 SHALL implement the states IDLE, PASS, DISC and ABORT; in_rdy is registered and equals 0 only in ABORT and in reset.
REQ-013 IDLE: a beat with in_sop=0 SHALL be discarded and orphan pulsed for 1 cycle.
REQ-014 IDLE, beat with in_sop=1 and wr_afull=1: SHALL write nothing and go to DISC.
REQ-015 IDLE, beat with in_sop=1 and wr_afull=0: SHALL write the beat and set len=1; with in_eop=1 it SHALL stay in IDLE, otherwise go to PASS.
REQ-016 PASS, beat with in_sop=0: SHALL write the beat with len incremented and OR in_err into err_acc.
REQ-017 wr_eoc SHALL be 1 on an in_eop beat; wr_drop = err_acc | in_err | (len < MIN_LEN) on that beat, then go to IDLE.
REQ-018 PASS, beat without in_eop at which len reaches MAX_LEN: SHALL write it with wr_eoc=1 and wr_drop=1, pulse oversize and go to DISC.
REQ-019 PASS, beat with in_sop=1 (missing eop): SHALL write a filler beat (wr_data=0, wr_eoc=1, wr_drop=1), store the sop beat in a hold register and go to ABORT.
REQ-020 ABORT: SHALL last exactly 1 cycle and process the held beat under the IDLE rules (REQ-014/015).
REQ-021 DISC: SHALL discard beats until an in_eop beat, then return to IDLE; an in_sop beat in DISC SHALL be handled as in IDLE.
REQ-022 wr_drop SHALL be 0 whenever wr_eoc=0.
REQ-023 wr_afull SHALL be sampled only at sop; a cell admitted to the FIFO is never truncated by wr_afull.
REQ-024 len SHALL saturate and never wrap.
REQ-025 cell_cnt SHALL increment on every wr_eoc with wr_drop=0.
REQ-026 drop_cnt SHALL increment on every wr_eoc with wr_drop=1 and on every DISC entry caused by wr_afull.
REQ-027 Both counters SHALL wrap modulo 2**16.

Reset
REQ-028 Under rst_n=0, the following SHALL hold asynchronously: state=IDLE, in_rdy=0, all wr_* outputs = 0, oversize=0, orphan=0, counters=0, len=0, err_acc=0, hold register empty.
REQ-029 in_rdy SHALL rise on the first clk edge after rst_n deasserts.
REQ-030 A partially written cell SHALL be abandoned on reset; the downstream FIFO is reset in the same domain.

Configuration
REQ-031 With macro CELL_FRAMER_STAT_EN defined, cell_cnt and drop_cnt SHALL operate per REQ-025 to REQ-027.
REQ-032 With CELL_FRAMER_STAT_EN undefined, cell_cnt and drop_cnt SHALL be tied to 0 and no counter flops inferred; all other behaviour is unchanged.

Structure
REQ-033 State encodings (IDLE=0, PASS=1, DISC=2, ABORT=3) SHALL live in the shared cellfifo package/header.
REQ-034 The counters SHALL be a sub-module cell_framer_stat, instantiated only under CELL_FRAMER_STAT_EN.

Verification
REQ-035 4-beat cell (sop..eop), wr_afull=0 -> 4 wr_vld beats, 1-cycle latency, wr_eoc on beat 4, wr_drop=0, cell_cnt=1.
REQ-036 20-beat cell, MAX_LEN=16 -> beat 16 has wr_eoc=1 and wr_drop=1, oversize pulses, beats 17-20 are not written, drop_cnt=1.
REQ-037 sop with wr_afull=1, 5-beat cell -> no wr_vld, drop_cnt=1; the next cell with wr_afull=0 passes intact.
REQ-038 Cell A 3 beats without eop, then cell B sop -> filler beat (eoc=1, drop=1), in_rdy=0 for 1 cycle, then B written starting at its sop beat.
REQ-039 in_err=1 on beat 2 of a 3-beat cell -> wr_drop=1 on beat 3; an eop-only beat in IDLE -> orphan pulse, nothing written.
REQ-040 rst_n asserted mid-cell -> all outputs 0 immediately; after release a new cell is framed correctly.
